// File: rtl/fft_output_stream.sv
// Streams one FFT frame out of a multi-lane RAM, in natural or bit-reversed order,
// through a small credit-controlled skid FIFO onto a valid/ready output.
module fft_output_stream #(
  parameter int unsigned N      = 32,
  parameter int unsigned WORD   = 16,
  parameter int unsigned LANES  = 2,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             bitrev_en,
  output logic                             rd_en,
  output logic [LANES*$clog2(N)-1:0]       rd_addr,
  input  logic [LANES*2*WORD-1:0]          rd_data,
  output logic [LANES*2*WORD-1:0]          m_data,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic                             m_last,
  output logic                             busy,
  output logic                             done
);

  localparam int unsigned AW    = $clog2(N);
  localparam int unsigned BEATS = N / LANES;
  localparam int unsigned BW    = LANES * 2 * WORD;
  localparam int unsigned D     = RD_LAT + 2;
  localparam int unsigned PW    = $clog2(D);
  localparam int unsigned OW    = $clog2(D + 1);
  localparam int unsigned SUMW  = OW + 1;
  localparam int unsigned CW    = $clog2(BEATS) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t              state, state_next;
  logic                brev;
  logic [CW-1:0]       ic;
  logic [CW-1:0]       k;
  logic [RD_LAT-1:0]   pipe;
  logic [BW-1:0]       mem [D];
  logic [PW-1:0]       wptr, rptr;
  logic [OW-1:0]       occ;
  logic                wr_c, pop_c, last_c, issue_c, start_c, can_issue_c;
  logic [SUMW-1:0]     pending_c;
  logic [AW*LANES-1:0] addr_c;

  function automatic logic [AW-1:0] bit_reverse(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    for (int b = 0; b < int'(AW); b++) r[b] = a[int'(AW)-1-b];
    return r;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(D - 1)) ? '0 : p + PW'(1);
  endfunction

  assign wr_c    = pipe[RD_LAT-1];
  assign m_valid = (occ != '0);
  assign m_data  = mem[rptr];
  assign pop_c   = m_valid & m_ready;
  assign last_c  = (k == CW'(BEATS - 1));
  assign m_last  = m_valid & last_c;

  // Credit check: entries after this cycle's pop plus all reads still on their way must fit in D.
  always_comb begin
    pending_c = SUMW'(occ) + SUMW'(rd_en);
    for (int i = 0; i < int'(RD_LAT); i++) pending_c = pending_c + SUMW'(pipe[i]);
    can_issue_c = (pending_c < (SUMW'(D) + SUMW'(pop_c)));
  end

  // Next state; the first read is issued straight from IDLE on an accepted start.
  always_comb begin
    state_next = state;
    issue_c    = 1'b0;
    start_c    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          issue_c    = 1'b1;
          start_c    = 1'b1;
        end
      end
      RUN: begin
        if (can_issue_c) begin
          issue_c = 1'b1;
          if (ic == CW'(BEATS - 1)) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (pop_c && last_c) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Lane addresses for the read being issued this cycle.
  always_comb begin
    logic [CW-1:0] base;
    logic          sel;
    logic [AW-1:0] lane;
    base   = start_c ? '0 : ic;
    sel    = start_c ? bitrev_en : brev;
    lane   = '0;
    addr_c = '0;
    for (int j = 0; j < int'(LANES); j++) begin
      lane = AW'(int'(base) * int'(LANES) + j);
      addr_c[j*AW +: AW] = sel ? bit_reverse(lane) : lane;
    end
  end

  // Control registers: state, counters, read port, status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      brev    <= 1'b0;
      ic      <= '0;
      k       <= '0;
      rd_en   <= 1'b0;
      rd_addr <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
      done  <= (state == DRAIN) && pop_c && last_c;
      rd_en <= issue_c;
      if (issue_c) rd_addr <= addr_c;
      if (start_c) begin
        brev <= bitrev_en;
        ic   <= CW'(1);
        k    <= '0;
      end else begin
        if (issue_c) ic <= ic + CW'(1);
        if (pop_c)   k  <= k + CW'(1);
      end
    end
  end

  // In-flight tracker and FIFO pointers; clearing them on reset drops late RAM returns.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe <= '0;
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
    end else begin
      pipe[0] <= rd_en;
      for (int i = 1; i < int'(RD_LAT); i++) pipe[i] <= pipe[i-1];
      if (wr_c)  wptr <= ptr_inc(wptr);
      if (pop_c) rptr <= ptr_inc(rptr);
      occ <= occ + OW'(wr_c) - OW'(pop_c);
    end
  end

  // FIFO storage; emptiness is tracked by occ, so contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_c) mem[wptr] <= rd_data;
  end

endmodule

// File: tb/tb_fft_output_stream.sv
// Directed bench for fft_output_stream: three parameterisations, each with a RAM model.
module tb_fft_output_stream;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  // Instance A: N=32, LANES=2, RD_LAT=1
  logic         start_a, brev_a, rd_en_a, m_valid_a, m_ready_a, m_last_a, busy_a, done_a;
  logic [9:0]   rd_addr_a;
  logic [63:0]  rd_data_a, m_data_a;
  // Instance B: N=32, LANES=2, RD_LAT=3
  logic         start_b, brev_b, rd_en_b, m_valid_b, m_ready_b, m_last_b, busy_b, done_b;
  logic [9:0]   rd_addr_b;
  logic [63:0]  rd_data_b, m_data_b;
  // Instance C: N=64, LANES=4, RD_LAT=2
  logic         start_c, brev_c, rd_en_c, m_valid_c, m_ready_c, m_last_c, busy_c, done_c;
  logic [23:0]  rd_addr_c;
  logic [127:0] rd_data_c, m_data_c;

  logic [63:0]  cap [16];
  logic [63:0]  b_s1, b_s2, b_s3;
  logic [127:0] c_s1, c_s2;

  fft_output_stream dut_a (
    .clk(clk), .reset(reset), .start(start_a), .bitrev_en(brev_a),
    .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
    .m_data(m_data_a), .m_valid(m_valid_a), .m_ready(m_ready_a),
    .m_last(m_last_a), .busy(busy_a), .done(done_a));

  fft_output_stream #(.RD_LAT(3)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .bitrev_en(brev_b),
    .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .m_data(m_data_b), .m_valid(m_valid_b), .m_ready(m_ready_b),
    .m_last(m_last_b), .busy(busy_b), .done(done_b));

  fft_output_stream #(.N(64), .LANES(4), .RD_LAT(2)) dut_c (
    .clk(clk), .reset(reset), .start(start_c), .bitrev_en(brev_c),
    .rd_en(rd_en_c), .rd_addr(rd_addr_c), .rd_data(rd_data_c),
    .m_data(m_data_c), .m_valid(m_valid_c), .m_ready(m_ready_c),
    .m_last(m_last_c), .busy(busy_c), .done(done_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM contents: sample at address a is {re = a, im = a + 0x4000}
  function automatic logic [31:0] smp(input int a);
    logic [15:0] re;
    logic [15:0] im;
    re = 16'(a);
    im = 16'(a) + 16'h4000;
    return {re, im};
  endfunction

  function automatic int rev5(input int a);
    int r;
    r = 0;
    for (int b = 0; b < 5; b++) if (((a >> b) & 1) == 1) r = r | (1 << (4 - b));
    return r;
  endfunction

  function automatic logic [63:0] beat2(input int k, input bit br);
    logic [63:0] r;
    int a;
    r = '0;
    for (int j = 0; j < 2; j++) begin
      a = 2 * k + j;
      if (br) a = rev5(a);
      r[j*32 +: 32] = smp(a);
    end
    return r;
  endfunction

  function automatic logic [127:0] beat4(input int k);
    logic [127:0] r;
    r = '0;
    for (int j = 0; j < 4; j++) r[j*32 +: 32] = smp(4 * k + j);
    return r;
  endfunction

  // RAM models: data appears exactly RD_LAT cycles after rd_en
  always @(posedge clk) begin
    for (int j = 0; j < 2; j++)
      rd_data_a[j*32 +: 32] <= rd_en_a ? smp(int'(rd_addr_a[j*5 +: 5])) : 32'hDEADBEEF;
  end

  always @(posedge clk) begin
    for (int j = 0; j < 2; j++)
      b_s1[j*32 +: 32] <= rd_en_b ? smp(int'(rd_addr_b[j*5 +: 5])) : 32'hDEADBEEF;
    b_s2 <= b_s1;
    b_s3 <= b_s2;
  end
  assign rd_data_b = b_s3;

  always @(posedge clk) begin
    for (int j = 0; j < 4; j++)
      c_s1[j*32 +: 32] <= rd_en_c ? smp(int'(rd_addr_c[j*6 +: 6])) : 32'hDEADBEEF;
    c_s2 <= c_s1;
  end
  assign rd_data_c = c_s2;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic kick_a(input bit br);
    start_a = 1'b1;
    brev_a  = br;
    @(posedge clk); #1;
    start_a = 1'b0;
    brev_a  = ~br;
  endtask

  // Follows one frame of A from just after its start edge to the done cycle.
  task automatic stream_a(input bit br, input int ign);
    int lat;
    lat = 0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      lat = n;
      if (m_valid_a) break;
    end
    check("a_latency", 128'(lat), 128'(2));
    for (int k = 0; k < 16; k++) begin
      check("a_valid", 128'(m_valid_a), 128'(1));
      check("a_data", 128'(m_data_a), 128'(beat2(k, br)));
      check("a_last", 128'(m_last_a), 128'(k == 15));
      check("a_busy", 128'(busy_a), 128'(1));
      cap[k] = m_data_a;
      start_a = (k == ign);
      @(posedge clk); #1;
    end
    start_a = 1'b0;
    check("a_done", 128'(done_a), 128'(1));
    check("a_valid_end", 128'(m_valid_a), 128'(0));
    check("a_busy_end", 128'(busy_a), 128'(0));
  endtask

  initial begin
    int lat;
    int got;
    bit prev_stall;
    bit fin;
    logic [63:0] held;
    checks = 0;
    errors = 0;
    reset = 1'b1;
    start_a = 0; brev_a = 0; m_ready_a = 1;
    start_b = 0; brev_b = 0; m_ready_b = 0;
    start_c = 0; brev_c = 0; m_ready_c = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_a_outs", 128'({rd_en_a, m_valid_a, m_last_a, busy_a, done_a}), 128'(0));
    check("rst_a_addr", 128'(rd_addr_a), 128'(0));
    check("rst_b_outs", 128'({rd_en_b, m_valid_b, m_last_b, busy_b, done_b}), 128'(0));
    check("rst_c_outs", 128'({rd_en_c, m_valid_c, m_last_c, busy_c, done_c}), 128'(0));
    reset = 1'b0;
    @(posedge clk); #1;

    // Natural order frame
    kick_a(1'b0);
    stream_a(1'b0, 99);
    @(posedge clk); #1;
    check("a_done_pulse", 128'(done_a), 128'(0));

    // Bit-reversed frame with hand-computed beats
    kick_a(1'b1);
    stream_a(1'b1, 99);
    check("rev_beat0", 128'(cap[0]), 128'({smp(16), smp(0)}));
    check("rev_beat1", 128'(cap[1]), 128'({smp(24), smp(8)}));
    check("rev_beat15", 128'(cap[15]), 128'({smp(31), smp(15)}));
    @(posedge clk); #1;

    // Mid-frame start ignored, start on done cycle accepted back-to-back
    kick_a(1'b0);
    stream_a(1'b0, 5);
    kick_a(1'b0);
    stream_a(1'b0, 99);
    @(posedge clk); #1;

    // Reset on the 5th beat
    kick_a(1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      check("rst_pre_data", 128'(m_data_a), 128'(beat2(k, 1'b0)));
      @(posedge clk); #1;
    end
    check("rst_beat5", 128'(m_data_a), 128'(beat2(4, 1'b0)));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_mid_outs", 128'({rd_en_a, m_valid_a, m_last_a, busy_a, done_a}), 128'(0));
    check("rst_mid_addr", 128'(rd_addr_a), 128'(0));
    for (int n = 0; n < 6; n++) begin
      @(posedge clk); #1;
      check("rst_no_stale", 128'(m_valid_a), 128'(0));
    end
    kick_a(1'b0);
    stream_a(1'b0, 99);

    // RD_LAT=3 with random backpressure
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    got = 0;
    prev_stall = 1'b0;
    fin = 1'b0;
    held = '0;
    for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
      if (prev_stall) begin
        check("b_hold_valid", 128'(m_valid_b), 128'(1));
        check("b_hold_data", 128'(m_data_b), 128'(held));
      end
      if (done_b) begin
        fin = 1'b1;
      end else begin
        m_ready_b = 1'($urandom_range(0, 1));
        if (m_valid_b && m_ready_b) begin
          check("b_data", 128'(m_data_b), 128'(beat2(got, 1'b0)));
          check("b_last", 128'(m_last_b), 128'(got == 15));
          got++;
          prev_stall = 1'b0;
        end else begin
          prev_stall = m_valid_b;
          held = m_data_b;
        end
        @(posedge clk); #1;
      end
    end
    m_ready_b = 1'b1;
    check("b_done_seen", 128'(fin), 128'(1));
    check("b_beats", 128'(got), 128'(16));

    // N=64, LANES=4, RD_LAT=2
    start_c = 1'b1;
    @(posedge clk); #1;
    start_c = 1'b0;
    lat = 0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      lat = n;
      if (m_valid_c) break;
    end
    check("c_latency", 128'(lat), 128'(3));
    for (int k = 0; k < 16; k++) begin
      check("c_valid", 128'(m_valid_c), 128'(1));
      check("c_data", m_data_c, beat4(k));
      check("c_last", 128'(m_last_c), 128'(k == 15));
      @(posedge clk); #1;
    end
    check("c_done", 128'(done_c), 128'(1));
    check("c_valid_end", 128'(m_valid_c), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_output_stream.md
FFT_OUTPUT_STREAM -- requirements
Module: fft_output_stream

Interface
REQ-001 Parameter N, default 32, the FFT length; it SHALL be a power of two and at least 4.
REQ-002 Parameter WORD, default 16, the bits per real or imaginary part; each sample SHALL be 2*WORD bits wide, {re, im}.
REQ-003 Parameter LANES, default 2, the samples per beat; it SHALL be a power of two with LANES <= N/2.
REQ-004 Parameter RD_LAT, default 1, the fixed RAM read latency in cycles; its legal range SHALL be 1..4.
REQ-005 Derived constant AW = $clog2(N); derived constant BEATS = N/LANES.
REQ-006 clk  in  1  clock; all logic SHALL be rising-edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 start  in  1  single-cycle request to stream one frame.
REQ-009 bitrev_en  in  1  selects bit-reversed read order; it SHALL be sampled only on an accepted start.
REQ-010 rd_en  out  1  RAM read strobe.
REQ-011 rd_addr  out  LANES*AW  lane j address in bits [j*AW +: AW].
REQ-012 rd_data  in  LANES*2*WORD  RAM data, valid exactly RD_LAT cycles after rd_en.
REQ-013 m_data  out  LANES*2*WORD  output beat; lane j occupies bits [j*2*WORD +: 2*WORD].
REQ-014 m_valid  out  1  output beat valid.
REQ-015 m_ready  in  1  downstream accept.
REQ-016 m_last  out  1  marks the final beat of a frame.
REQ-017 busy  out  1  high while a frame is in progress.
REQ-018 done  out  1  one-cycle pulse after the last beat is accepted.

Function
REQ-019 The block SHALL have the states IDLE, RUN and DRAIN.
REQ-020 IDLE -> RUN on start; the block SHALL latch bitrev_en and clear beat counter k and the issue counter.
REQ-021 RUN issues one read per cycle while (FIFO occupancy + reads in flight) < D, with D = RD_LAT+2, until BEATS reads are issued; it SHALL then move to DRAIN.
REQ-022 The address of lane j on issue number i SHALL be a = i*LANES + j in natural order, or bitreverse_AW(a) when the latched bitrev_en = 1.
REQ-023 rd_addr SHALL be held at its last value whenever rd_en = 0.
REQ-024 Returned rd_data SHALL be written into an internal FIFO of depth D; the FIFO SHALL never overflow and nothing SHALL be dropped.
REQ-025 m_valid = FIFO not empty; m_data SHALL be the FIFO head; a beat transfers when m_valid and m_ready are both high.
REQ-026 m_data SHALL remain stable while m_valid = 1 and m_ready = 0.
REQ-027 m_last SHALL be 1 exactly on the output beat with k = BEATS-1.
REQ-028 DRAIN -> IDLE when the m_last beat transfers; done SHALL pulse in the following cycle.
REQ-029 busy SHALL be 1 in RUN and DRAIN, and 0 in IDLE.
REQ-030 With m_ready held at 1, the first m_valid SHALL rise RD_LAT+1 cycles after start, and all BEATS beats SHALL be delivered on consecutive cycles.
REQ-031 start while busy = 1 SHALL be ignored, with no change to the current frame.
REQ-032 start in the same cycle as the done pulse SHALL be accepted, so frames run back-to-back.
REQ-033 Counters SHALL be width $clog2(BEATS)+1; they SHALL NOT wrap within a frame.

Reset
REQ-034 On reset, state SHALL return to IDLE, and rd_en, m_valid, m_last, busy and done SHALL be 0.
REQ-035 On reset, rd_addr SHALL be 0 and the FIFO and all counters SHALL be cleared.
REQ-036 Reset during RUN or DRAIN SHALL abort the frame.
REQ-037 RAM data arriving after a reset SHALL be discarded, using an in-flight valid shift register of length RD_LAT that is cleared by reset.
REQ-038 Reset SHALL take priority over start in the same cycle.

Verification
REQ-039 N=32, LANES=2, RD_LAT=1, bitrev_en=0, m_ready=1, with the RAM holding word = address -> 16 consecutive beats {0,1},{2,3}..{30,31}, m_last on beat 16, done one cycle later.
REQ-040 Same setup with bitrev_en=1 -> beat 0 = {0,16}, beat 1 = {8,24}, last beat = {15,31}.
REQ-041 RD_LAT=3, with m_ready toggled by a random 50% pattern -> all 32 samples are delivered in order, with no duplicate or missing sample and m_data stable while stalled.
REQ-042 Reset asserted on the 5th beat with m_ready=1 -> all outputs are 0 the next cycle, no stale beat appears, and a following start streams a full correct frame.
REQ-043 start pulsed mid-frame, then again on the done cycle -> the first is ignored, and the second frame's first m_valid occurs RD_LAT+1 cycles after it.
REQ-044 N=64, LANES=4, RD_LAT=2 -> 16 beats, lane j of beat k equals 4k+j, and m_last occurs only on k=15.
